// File: rtl/booth_divider.sv
// Sequential signed divider: start, then dividend, then divisor on data_in.
// Restoring division on operand magnitudes over WIDTH cycles.
// Signs are applied in a final FIX cycle: the quotient truncates toward zero,
// and the remainder takes the sign of the dividend.
module booth_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;      // captured dividend (raw two's complement)
  logic             r_sa;     // dividend sign
  logic             r_sb;     // divisor sign
  logic [WIDTH-1:0] r_q;      // dividend magnitude shifting out / quotient bits shifting in
  logic [WIDTH-1:0] r_m;      // divisor magnitude
  logic [WIDTH:0]   r_r;      // partial remainder
  logic [CW-1:0]    r_count;  // iterations left

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_r_low;

  // Operand magnitudes and one restoring-division step.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    w_a_mag  = r_a;
    w_b_mag  = data_in;
    w_shift  = {r_r, r_q[WIDTH-1]};
    w_diff   = w_shift - {2'b00, r_m};
    w_fits   = ~w_diff[WIDTH+1];
    w_q_next = {r_q[WIDTH-2:0], w_fits};
    w_r_next = w_shift[WIDTH:0];
    w_r_low  = r_r[WIDTH-1:0];
    // Negating the most negative value wraps to itself.
    // Read unsigned, that is exactly 2^(WIDTH-1).
    if (r_a[WIDTH-1])     w_a_mag  = -r_a;
    if (data_in[WIDTH-1]) w_b_mag  = -data_in;
    if (w_fits)           w_r_next = w_diff[WIDTH:0];
  end

  // Control FSM plus datapath registers and registered outputs.
  // NOTE: all state here is updated with non-blocking assignments.
  // Every register therefore sees the values from before the edge,
  // whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_q         <= '0;
      r_m         <= '0;
      r_r         <= '0;
      r_count     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state <= S_LDA;
            done    <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_LDA: begin
          r_a     <= data_in;
          r_sa    <= data_in[WIDTH-1];
          r_state <= S_LDB;
        end

        S_LDB: begin
          r_sb <= data_in[WIDTH-1];
          if (data_in == '0) begin
            quotient    <= '1;
            remainder   <= r_a;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            r_state     <= S_DONE;
          end else begin
            r_q     <= w_a_mag;
            r_m     <= w_b_mag;
            r_r     <= '0;
            r_count <= CW'(WIDTH);
            r_state <= S_DIV;
          end
        end

        S_DIV: begin
          r_q     <= w_q_next;
          r_r     <= w_r_next;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) r_state <= S_FIX;
        end

        S_FIX: begin
          // The remainder magnitude is below |divisor|, so its low WIDTH bits hold it.
          quotient    <= (r_sa ^ r_sb) ? -r_q : r_q;
          remainder   <= r_sa ? -w_r_low : w_r_low;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_DONE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Directed bench for booth_divider.
// Each operation pushes its expected result, computed with signed integer
// division, onto a scoreboard. The result is popped and compared when done rises.
module tb_booth_divider;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t last;

  booth_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in    (data_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    int   sa;
    int   sb_i;
    sa   = int'($signed(a));
    sb_i = int'($signed(b));
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = WIDTH'(sa / sb_i);
      e.r   = WIDTH'(sa % sb_i);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // One full operation from T0.
  // When tog is set, start and data_in are randomised wherever they must be ignored.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit tog, input int exp_lat);
    int   n;
    exp_t e;
    start   = 1'b1;
    data_in = WIDTH'($urandom);
    tick();                                  // T0
    check({tag, "_busy_t0"}, {31'd0, busy}, 32'd1);
    check({tag, "_done_t0"}, {31'd0, done}, 32'd0);
    check({tag, "_hold_q_t0"}, {16'd0, quotient}, {16'd0, last.q});
    data_in = a;
    start   = tog ? 1'($urandom) : 1'b0;
    tick();                                  // T1
    data_in = b;
    start   = tog ? 1'($urandom) : 1'b0;
    sb.push_back(model(a, b));
    tick();                                  // T2
    n = 2;
    while (!done && n < 40) begin
      start   = (tog && n < 18) ? 1'($urandom) : 1'b0;
      data_in = WIDTH'($urandom);
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_sb_nonempty"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, e.q});
      check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, e.r});
      check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
      last = e;
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    last    = '0;
    tick();
    tick();
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {16'd0, remainder}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_no_start", {30'd0, done, busy}, 32'd0);

    run_op("m10_3", 16'hFFF6, 16'd3, 1'b0, 19);
    run_op("p13_m10", 16'd13, 16'hFFF6, 1'b0, 19);
    run_op("m10_p13", 16'hFFF6, 16'd13, 1'b0, 19);
    run_op("div0", 16'd100, 16'd0, 1'b0, 2);
    run_op("p100_7", 16'd100, 16'd7, 1'b0, 19);
    run_op("min_m1", 16'h8000, 16'hFFFF, 1'b0, 19);
    run_op("max_1", 16'h7FFF, 16'd1, 1'b0, 19);

    // Abort 1000/7 part-way through the iterations with an asynchronous reset.
    start   = 1'b1;
    tick();                                  // T0
    data_in = 16'd1000;
    start   = 1'b0;
    tick();                                  // T1
    data_in = 16'd7;
    tick();                                  // T2
    for (int i = 0; i < 8; i++) tick();      // iterations 1..8
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {16'd0, remainder}, 32'd0);
    check("abort_flags", {29'd0, done, busy, div_by_zero}, 32'd0);
    tick();
    rst = 1'b0;
    last = '0;
    for (int i = 0; i < 25; i++) tick();
    check("abort_stays_idle", {30'd0, done, busy}, 32'd0);

    run_op("p1000_7", 16'd1000, 16'd7, 1'b0, 19);
    run_op("m10_3_noisy", 16'hFFF6, 16'd3, 1'b1, 19);
    tick();
    check("done_held", {31'd0, done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_divider.md
# booth_divider

Sequential signed integer divider, the inverse companion of the team's Booth multiplier. It uses the same start/serial-operand protocol: `start`, then the dividend on `data_in`, then the divisor on `data_in`. It computes quotient and remainder by restoring division over WIDTH iteration cycles. The block is split into a datapath (operand, remainder and quotient registers, subtractor, counter) and an FSM control path, and sits alongside the multiplier in the arithmetic unit.

## Interface
- WIDTH, 16, operand width in bits (two's complement).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin an operation; sampled only in IDLE and DONE.
- data_in  input  WIDTH  dividend (first cycle after start), then divisor (second cycle).
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- done  output  1  high while quotient/remainder hold a completed result.
- busy  output  1  high in LDA, LDB, DIV, FIX.
- div_by_zero  output  1  high with done when the divisor was 0.

## Operation
- States: IDLE, LDA, LDB, DIV, FIX, DONE.
- IDLE: if start=1, go to LDA. Otherwise stay.
- LDA: register A = data_in (dividend). Record sign sA. Go to LDB.
- LDB: register B = data_in (divisor). Record sign sB.
  - If B == 0: quotient <= all ones, remainder <= A, div_by_zero <= 1, go to DONE.
  - Else: load the unsigned magnitudes |A| into Q and |B| into M, clear R (WIDTH+1 bits), set count = WIDTH, go to DIV.
- DIV, once per cycle:
  - Shift {R,Q} left by 1.
  - D = R − M.
  - If D ≥ 0: R = D and Q[0] = 1. Else R is unchanged and Q[0] = 0.
  - Decrement count. After the WIDTH-th iteration, go to FIX.
- FIX:
  - quotient <= (sA^sB) ? −Q : Q.
  - remainder <= sA ? −R : R.
  - div_by_zero <= 0.
  - Go to DONE.
- Magnitude rules:
  - |−2^(WIDTH−1)| = 2^(WIDTH−1), held in WIDTH unsigned bits.
  - Negation is modulo 2^WIDTH.
  - So (−2^(WIDTH−1)) / (−1) gives quotient 0x8000 (wrap) and remainder 0, with no flag.
- DONE: done=1. Outputs are held. If start=1, go to LDA; done drops on that edge, and quotient/remainder keep their old values until the next FIX.
- start is ignored in LDA, LDB, DIV and FIX.
- quotient, remainder and div_by_zero are registers. They change only on the FIX edge or the LDB divide-by-zero edge, or on reset.

## Timing
- Reset (async, any state): state = IDLE; quotient = 0, remainder = 0, done = 0, busy = 0, div_by_zero = 0; internal registers cleared.
- Edge numbering: T0 is the edge that samples start=1 in IDLE/DONE.
  - T1 captures the dividend.
  - T2 captures the divisor.
  - T3..T(2+WIDTH) are the iterations.
  - T(3+WIDTH) is FIX.
- done rises after T(3+WIDTH): 19 edges after T0 for WIDTH=16.
- Divide-by-zero: done and div_by_zero rise after T2.
- busy is high from after T0 until the edge on which done rises.
- data_in must be stable around T1 and T2. It is don't-care at all other times.
- Back-to-back: start=1 in DONE at edge Tn acts as T0 of the next operation.
- Reset asserted mid-DIV aborts the operation. After release, start is needed again.

## Test plan
- Reset, then start; dividend −10, divisor 3 -> after 19 edges from T0: quotient = 0xFFFD (−3), remainder = 0xFFFF (−1), done = 1, div_by_zero = 0.
- Dividend 13, divisor −10 -> quotient = 0xFFFF (−1), remainder = 3. Then dividend −10, divisor 13 (back-to-back start in DONE) -> quotient = 0, remainder = 0xFFF6.
- Dividend 100, divisor 0 -> after T2: done = 1, div_by_zero = 1, quotient = 0xFFFF, remainder = 100. Then dividend 100, divisor 7 -> quotient = 14, remainder = 2, div_by_zero = 0.
- Dividend 0x8000, divisor 0xFFFF -> quotient = 0x8000, remainder = 0. Dividend 0x7FFF, divisor 1 -> quotient = 0x7FFF, remainder = 0.
- rst pulsed at iteration 8 of 1000/7 -> all outputs 0 and state IDLE immediately. A new start with 1000/7 -> quotient = 142, remainder = 6.
- start toggled during DIV, and data_in randomized outside T1/T2 -> result unaffected (−10/3 still gives −3 and −1), with done timing exactly 19 edges after T0.
